// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scanner: FSM encoding, widths,
// reset constants and small row-decoding helpers.
package keypad_pkg;

  localparam int KEY_W = 4;
  localparam logic [3:0] COL_RESET = 4'b1110;

  typedef enum logic [1:0] {
    SCAN  = 2'd0,
    PRESS = 2'd1,
    HOLD  = 2'd2
  } kp_state_e;

  // True when exactly one of the four active-low lines is low.
  function automatic logic single_low(input logic [3:0] lines);
    logic r;
    r = 1'b0;
    case (lines)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: r = 1'b1;
      default:                            r = 1'b0;
    endcase
    return r;
  endfunction

  // Index of the low line; only meaningful when single_low() is true.
  function automatic logic [1:0] low_index(input logic [3:0] lines);
    logic [1:0] idx;
    idx = 2'd0;
    case (lines)
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scan_tick.sv
// Free-running prescaler: counts 0..SCAN_DIV-1 and raises tick_o for one
// clock at the terminal count. Shared with the display multiplexer.
module scan_tick #(
  parameter int SCAN_DIV = 50000
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic tick_o
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] TERM = CW'(SCAN_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick_o = (cnt_q == TERM);

  // Wrap to zero on the terminal count, otherwise advance.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (tick_o) cnt_d = '0;
  end

  // Prescaler register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner. One column is driven low at a time; the
// synchronized rows are examined once per scan tick. A single low row is
// debounced for DEBOUNCE ticks before the key code is published with a
// one-clock key_valid strobe; a full debounced release re-arms scanning.
//
// key_valid is a pure strobe with no ready: the consumer must take key on
// the single cycle key_valid is high; key stays stable afterwards anyway.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter int DEBOUNCE = 10
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [3:0]       row,
  output logic [3:0]       col,
  output logic [KEY_W-1:0] key,
  output logic             key_valid,
  output logic             key_held,
  output logic [1:0]       dbg_state
);

  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE - 1);

  logic             tick;
  logic [3:0]       row_meta_q;
  logic [3:0]       row_s_q;
  kp_state_e        state_q, state_d;
  logic [3:0]       col_q, col_d;
  logic [1:0]       row_idx_q, row_idx_d;
  logic [1:0]       col_idx_q, col_idx_d;
  logic [DW-1:0]    cnt_q, cnt_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic             key_valid_q, key_valid_d;
  logic             sample_single;
  logic [1:0]       sample_row;

  scan_tick #(
    .SCAN_DIV(SCAN_DIV)
  ) u_tick (
    .clk_i (clk),
    .rst_ni(clr),
    .tick_o(tick)
  );

  // Two-flop synchronizer for the asynchronous row lines (idle high).
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      row_meta_q <= 4'hF;
      row_s_q    <= 4'hF;
    end else begin
      row_meta_q <= row;
      row_s_q    <= row_meta_q;
    end
  end

  assign sample_single = single_low(row_s_q);
  assign sample_row    = low_index(row_s_q);

  // Next-state logic: scan / debounce press / debounce release.
  // One counter serves both the press and the release debounce.
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_idx_d   = row_idx_q;
    col_idx_d   = col_idx_q;
    cnt_d       = cnt_q;
    key_d       = key_q;
    key_valid_d = 1'b0;
    case (state_q)
      SCAN: begin
        if (tick) begin
          if (sample_single) begin
            row_idx_d = sample_row;
            col_idx_d = low_index(col_q);
            cnt_d     = '0;
            state_d   = PRESS;
          end else begin
            col_d = {col_q[2:0], col_q[3]};
          end
        end
      end
      PRESS: begin
        if (tick) begin
          if (sample_single && (sample_row == row_idx_q)) begin
            if (cnt_q == DB_LAST) begin
              key_d       = {row_idx_q, col_idx_q};
              key_valid_d = 1'b1;
              cnt_d       = '0;
              state_d     = HOLD;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else begin
            // Bounce or different row: resample this same column.
            state_d = SCAN;
          end
        end
      end
      HOLD: begin
        if (tick) begin
          if (row_s_q == 4'hF) begin
            if (cnt_q == DB_LAST) begin
              cnt_d   = '0;
              state_d = SCAN;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else begin
            cnt_d = '0;
          end
        end
      end
      default: state_d = SCAN;
    endcase
  end

  // FSM and datapath registers.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q     <= SCAN;
      col_q       <= COL_RESET;
      row_idx_q   <= 2'd0;
      col_idx_q   <= 2'd0;
      cnt_q       <= '0;
      key_q       <= '0;
      key_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_idx_q   <= row_idx_d;
      col_idx_q   <= col_idx_d;
      cnt_q       <= cnt_d;
      key_q       <= key_d;
      key_valid_q <= key_valid_d;
    end
  end

  assign col       = col_q;
  assign key       = key_q;
  assign key_valid = key_valid_q;
  assign key_held  = (state_q == HOLD);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan with SCAN_DIV = 4, DEBOUNCE = 3. A keypad model
// turns the set of pressed keys into row levels from the driven column; a
// tick-level reference model predicts col/key/key_valid/key_held each cycle.
module tb_keypad_scan;
  import keypad_pkg::*;

  localparam int SD = 4;
  localparam int DB = 3;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key;
  logic       key_valid;
  logic       key_held;
  logic [1:0] dbg_state;
  logic [15:0] pressed = '0;

  always #5 clk = ~clk;

  keypad_scan #(
    .SCAN_DIV(SD),
    .DEBOUNCE(DB)
  ) dut (
    .clk      (clk),
    .clr      (clr),
    .row      (row),
    .col      (col),
    .key      (key),
    .key_valid(key_valid),
    .key_held (key_held),
    .dbg_state(dbg_state)
  );

  // Physical keypad: a pressed key pulls its row low while its column is low.
  function automatic logic [3:0] keypad_rows(input logic [15:0] p, input logic [3:0] c);
    logic [3:0] r;
    r = 4'hF;
    for (int ri = 0; ri < 4; ri++)
      for (int ci = 0; ci < 4; ci++)
        if (p[ri*4+ci] && !c[ci]) r[ri] = 1'b0;
    return r;
  endfunction

  function automatic logic [3:0] col_of(input int c);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << c);
  endfunction

  assign row = keypad_rows(pressed, col);

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;
  int dut_valids = 0;
  logic [3:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [3:0] m_meta, m_s, m_sample;
  int   m_edge;
  int   m_col;        // index of the low column
  int   m_cand_row;   // row being debounced, -1 when none
  int   m_streak;
  int   m_quiet;
  bit   m_held;
  bit   m_valid;
  int   m_key;
  int   m_accepts = 0;

  task automatic model_reset();
    m_meta = 4'hF; m_s = 4'hF; m_edge = 0; m_col = 0;
    m_cand_row = -1; m_streak = 0; m_quiet = 0;
    m_held = 1'b0; m_valid = 1'b0; m_key = 0;
  endtask

  task automatic model_tick(input logic [3:0] s);
    int zeros, r;
    zeros = 0; r = 0;
    for (int i = 0; i < 4; i++) if (!s[i]) begin zeros++; r = i; end
    if (m_held) begin
      if (s == 4'hF) m_quiet++; else m_quiet = 0;
      if (m_quiet == DB) begin m_held = 1'b0; m_quiet = 0; end
    end else if (m_cand_row >= 0) begin
      if (zeros == 1 && r == m_cand_row) begin
        m_streak++;
        if (m_streak == DB) begin
          m_key = m_cand_row * 4 + m_col;
          m_valid = 1'b1;
          m_held = 1'b1;
          m_cand_row = -1;
          m_accepts++;
          exp_q.push_back(4'(m_key));
        end
      end else begin
        m_cand_row = -1;
      end
    end else if (zeros == 1) begin
      m_cand_row = r;
      m_streak = 0;
    end else begin
      m_col = (m_col + 1) % 4;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge clr);
      if (!clr) begin
        model_reset();
      end else begin
        m_sample = m_s;
        m_s      = m_meta;
        m_meta   = keypad_rows(pressed, col_of(m_col));
        m_edge++;
        m_valid  = 1'b0;
        if (m_edge % SD == 0) model_tick(m_sample);
      end
    end
  end

  // Per-cycle scoreboard, sampled on the falling edge.
  initial begin
    logic [3:0] exp_key;
    forever begin
      @(negedge clk);
      if (clr) begin
        chk("col", col, col_of(m_col));
        chk("key", key, m_key);
        chk("key_valid", key_valid, m_valid);
        chk("key_held", key_held, m_held);
        if (key_valid === 1'b1) begin
          dut_valids++;
          chk("valid_queue", exp_q.size(), 1);
          if (exp_q.size() > 0) begin
            exp_key = exp_q.pop_front();
            chk("valid_key", key, exp_key);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_key(input int r, input int c);
    pressed = 16'(1) << (r * 4 + c);
  endtask

  task automatic release_all();
    pressed = '0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base, k, c, budget;
    bit reached;

    clr = 1'b0;
    wait_cycles(3);
    chk("rst_col", col, 4'b1110);
    chk("rst_key", key, 0);
    chk("rst_valid", key_valid, 0);
    chk("rst_held", key_held, 0);
    clr = 1'b1;

    // Idle scanning.
    wait_cycles(40);
    chk("idle_valids", dut_valids, 0);
    chk("idle_key", key, 0);

    // Steady press of row 2 / col 1.
    press_key(2, 1);
    wait_cycles(80);
    chk("s2_valids", dut_valids, 1);
    chk("s2_key", key, 9);
    chk("s2_held", key_held, 1);
    chk("s2_col", col, 4'b1101);

    // Release.
    release_all();
    wait_cycles(40);
    chk("s3_held", key_held, 0);
    chk("s3_key", key, 9);
    chk("s3_state", dbg_state, SCAN);

    // Bounce: pulses of at most one tick period.
    base = dut_valids;
    for (int i = 0; i < 6; i++) begin
      k = $urandom_range(0, 15);
      pressed = 16'(1) << k;
      wait_cycles($urandom_range(1, SD));
      release_all();
      wait_cycles($urandom_range(SD + 1, 3 * SD));
    end
    wait_cycles(5 * SD);
    chk("s4_valids", dut_valids, base);
    chk("s4_state", dbg_state, SCAN);

    // Two rows low in one column.
    c = $urandom_range(0, 3);
    pressed = (16'(1) << c) | (16'(1) << (12 + c));
    wait_cycles(60);
    chk("s5_valids", dut_valids, base);
    release_all();
    wait_cycles(20);

    // Reset pulse while a press is being debounced.
    press_key($urandom_range(0, 3), $urandom_range(0, 3));
    reached = 1'b0;
    budget = 60;
    while (!reached && budget > 0) begin
      @(negedge clk);
      budget--;
      if (m_cand_row >= 0) reached = 1'b1;
    end
    chk("s6_reach_press", reached, 1);
    #1 clr = 1'b0;
    #1;
    chk("s6_col", col, 4'b1110);
    chk("s6_key", key, 0);
    chk("s6_valid", key_valid, 0);
    chk("s6_held", key_held, 0);
    release_all();
    wait_cycles(2);
    clr = 1'b1;
    wait_cycles(4 * SD);
    chk("s6_no_valid", dut_valids, base);
    press_key(0, 3);
    wait_cycles(80);
    chk("s6_key3", key, 3);
    chk("s6_valids", dut_valids, base + 1);
    release_all();
    wait_cycles(40);

    // Random presses, occasionally two keys at once.
    for (int i = 0; i < 10; i++) begin
      k = $urandom_range(0, 15);
      pressed = 16'(1) << k;
      if ($urandom_range(0, 3) == 0) pressed = pressed | (16'(1) << $urandom_range(0, 15));
      wait_cycles($urandom_range(5, 80));
      release_all();
      wait_cycles($urandom_range(5, 60));
    end
    wait_cycles(60);

    chk("total_valids", dut_valids, m_accepts);
    chk("exp_q_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_scan.md
# keypad_scan

Scanner for a 4x4 matrix keypad, the input-side counterpart of the multiplexed seven-segment display driver. It drives one column low at a time, samples the four row lines, debounces a single key press and emits a 4-bit key code with a one-cycle valid strobe. The strobe can feed the BCD counter's `load`/`in` inputs directly, replacing raw switches on the board top level.

## Interface
- `SCAN_DIV`, default 50000: `clk` cycles per scan tick (1 ms at 50 MHz); minimum 2.
- `DEBOUNCE`, default 10: consecutive matching scan ticks required to accept a press or a release; minimum 1.

- `clk` input 1: system clock.
- `clr` input 1: asynchronous, active-low reset.
- `row` input 4: keypad rows, active-low, externally pulled up, asynchronous to `clk`.
- `col` output 4: keypad columns, exactly one bit low at all times.
- `key` output 4: code of the last accepted key, `row_idx*4 + col_idx`.
- `key_valid` output 1: one-`clk` pulse when a new press is accepted.
- `key_held` output 1: high while the accepted key stays pressed.

## Operation
- `row` passes through a 2-flop synchronizer. All decisions use the synchronized value `row_s`.
- The prescaler counts 0 to SCAN_DIV-1 and asserts `tick` for one cycle at the terminal count. All FSM actions happen only on `tick` cycles.
- A row sample is "single" when exactly one bit of `row_s` is 0. Zero or several low bits count as "none". Ghosting and multi-key input are ignored.
- FSM states:
  - SCAN: on `tick`, if the sample is single, latch `col_idx` and `row_idx`, clear the debounce count, go to PRESS. Otherwise rotate `col` left one position (1110 → 1101 → 1011 → 0111 → 1110).
  - PRESS: `col` is frozen. On `tick`, if the same single row is low, increment the count. When the count reaches DEBOUNCE, load `key`, pulse `key_valid`, go to HOLD. On any mismatch, go back to SCAN with `col` unchanged.
  - HOLD: `key_held` = 1 and `col` is frozen. On `tick`, if `row_s` = 1111, increment the release count; otherwise clear it. When the count reaches DEBOUNCE, go to SCAN with `key_held` = 0.
- `key` holds its value until the next accepted press. It is never cleared on release.
- Reset values: `col` = 1110, `key` = 0, `key_valid` = 0, `key_held` = 0, state SCAN, all counters 0. `clr` asserted at any point aborts the press immediately with no `key_valid`.

## Timing
- `col` is stable for SCAN_DIV cycles before it is sampled. Sampling and column advance happen on the same `tick` edge, and the sample refers to the old column.
- Press-to-`key_valid` latency, for a stable press: 2 sync cycles, plus up to 4 ticks to reach the column, plus DEBOUNCE ticks.
- `key_valid` and the new `key` value are registered together. `key` is valid on the cycle `key_valid` is high.
- `key_held` rises on the same edge as `key_valid` and falls DEBOUNCE release ticks after the last low row sample.
- At most one `key_valid` per press. A new `key_valid` requires a full release followed by a new debounce.

## Structure
- Shared package `keypad_pkg`: FSM state encoding (SCAN, PRESS, HOLD) and the constants `KEY_W` = 4 and `COL_RESET` = 4'b1110.
- One sub-module, `scan_tick`: the SCAN_DIV prescaler with a `tick` output, reusable by the display multiplexer.
- Counter widths are $clog2 of SCAN_DIV and of DEBOUNCE+1.

## Test plan
All scenarios use SCAN_DIV = 4 and DEBOUNCE = 3.
- Reset, no key pressed: `col` cycles 1110, 1101, 1011, 0111 every 4 clk. `key_valid` never pulses. `key` stays 0.
- Key at row 2 / col 1 held steady: exactly one `key_valid`, with `key` = 9 and `key_held` = 1. `col` stays frozen at 1101 while held.
- Same key released: `key_held` falls 3 ticks after the rows return to 1111, scanning resumes, `key` stays 9.
- Key bouncing with 1-tick pulses shorter than DEBOUNCE: no `key_valid`, FSM returns to SCAN.
- Two rows low in the same column: treated as no key, no `key_valid`, scanning continues.
- `clr` pulsed low during PRESS: outputs return to reset values at once, no `key_valid`. A later clean press of row 0 / col 3 gives `key` = 3.
